// File: rtl/tfr_mem_rd_if.sv
// tfr_mem_rd_if: support-CPU register bus plus SDRAM byte-read handshake
interface tfr_mem_rd_if;
  logic [3:0]  A_i;
  logic [7:0]  D_i;
  logic [7:0]  D_o;
  logic        nWR_i;
  logic        nRD_i;
  logic [23:0] mem_A_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [7:0]  mem_D_i;
  modport slave (
    input  A_i, D_i, nWR_i, nRD_i, mem_ack_i, mem_D_i,
    output D_o, mem_A_o, mem_req_o
  );
  modport master (
    output A_i, D_i, nWR_i, nRD_i, mem_ack_i, mem_D_i,
    input  D_o, mem_A_o, mem_req_o
  );
endinterface

// File: rtl/tfr_mem_rd.sv
// tfr_mem_rd: CPU-windowed SDRAM byte read-back with auto-increment prefetch
module tfr_mem_rd #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic busclk_i,
  input logic nreset_i,
  tfr_mem_rd_if.slave bus
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t      state;
  logic        prev_rd, prev_wr, valid, err, discard;
  logic [23:0] addr, addr_rd, addr_nx;
  logic [7:0]  buffer, cnt, rd_val;
  logic        rd_edge, wr_edge, rd_data, wr_addr, start, launch, ack, timeout;
  // strobe edges, register-map decode and next-address arithmetic
  always_comb begin
    rd_edge = prev_rd & ~bus.nRD_i;
    wr_edge = prev_wr & ~bus.nWR_i;
    rd_data = rd_edge && bus.A_i == 4'hF && valid;
    wr_addr = wr_edge && bus.A_i <= 4'h2;
    start   = wr_edge && bus.A_i == 4'h3 && bus.D_i[0] && state == IDLE;
    launch  = state == IDLE && (start || rd_data);
    ack     = state == REQ && bus.mem_ack_i;
    timeout = state == REQ && !bus.mem_ack_i && cnt == 8'(TIMEOUT - 1);
    addr_rd = rd_data ? addr + 24'd1 : addr;
    addr_nx = !wr_addr ? addr_rd :
              bus.A_i == 4'h0 ? {addr_rd[23:8], bus.D_i} :
              bus.A_i == 4'h1 ? {addr_rd[23:16], bus.D_i, addr_rd[7:0]} :
                                {bus.D_i, addr_rd[15:0]};
    rd_val  = bus.A_i == 4'h0 ? addr[7:0] :
              bus.A_i == 4'h1 ? addr[15:8] :
              bus.A_i == 4'h2 ? addr[23:16] :
              bus.A_i == 4'h3 ? {5'b0, err, state == REQ, valid} :
              (bus.A_i == 4'hF && valid) ? buffer : 8'hFF;
  end
  // previous strobe levels so each access acts once per falling edge
  always_ff @(posedge busclk_i or negedge nreset_i)
    if (!nreset_i) begin
      prev_rd <= 1'b1;
      prev_wr <= 1'b1;
    end else begin
      prev_rd <= bus.nRD_i;
      prev_wr <= bus.nWR_i;
    end
  // registered read data, sampled from pre-write state
  always_ff @(posedge busclk_i or negedge nreset_i)
    if (!nreset_i) bus.D_o <= 8'h00;
    else if (rd_edge) bus.D_o <= rd_val;
  // address register and status flags
  always_ff @(posedge busclk_i or negedge nreset_i)
    if (!nreset_i) begin
      addr  <= 24'h0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      addr  <= addr_nx;
      valid <= (ack && !discard && !wr_addr) ? 1'b1 : (rd_data || wr_addr || start) ? 1'b0 : valid;
      err   <= start ? 1'b0 : timeout ? 1'b1 : err;
    end
  // fetch FSM: a write to the address during REQ poisons the byte in flight
  always_ff @(posedge busclk_i or negedge nreset_i)
    if (!nreset_i) begin
      state         <= IDLE;
      bus.mem_A_o   <= 24'h0;
      bus.mem_req_o <= 1'b0;
      cnt           <= 8'h0;
      buffer        <= 8'hFF;
      discard       <= 1'b0;
    end else if (state == IDLE) begin
      if (launch) begin
        state         <= REQ;
        bus.mem_A_o   <= addr_nx;
        bus.mem_req_o <= 1'b1;
        cnt           <= 8'h0;
      end
    end else if (ack || timeout) begin
      state         <= IDLE;
      bus.mem_req_o <= 1'b0;
      discard       <= 1'b0;
      buffer        <= timeout ? 8'hFF : (discard || wr_addr) ? buffer : bus.mem_D_i;
    end else begin
      cnt     <= cnt + 8'd1;
      discard <= discard | wr_addr;
    end
endmodule

// File: tb/tb_tfr_mem_rd.sv
// tb_tfr_mem_rd: directed scoreboard bench for the SDRAM read-back block
module tb_tfr_mem_rd;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0]  rd_q[$];
  logic [23:0] fa_q[$];
  tfr_mem_rd_if bus();
  tfr_mem_rd #(.TIMEOUT(255)) dut (.busclk_i(clk), .nreset_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.A_i = a;
    bus.D_i = d;
    bus.nWR_i = 1'b0;
    @(negedge clk);
    bus.nWR_i = 1'b1;
  endtask
  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string tag, input int hold = 1);
    rd_q.push_back(e);
    @(negedge clk);
    bus.A_i = a;
    bus.nRD_i = 1'b0;
    repeat (hold) @(negedge clk);
    bus.nRD_i = 1'b1;
    chk(tag, {24'h0, bus.D_o}, {24'h0, rd_q.pop_front()});
  endtask
  task automatic fetch(input string tag);
    int n = 0;
    while (!bus.mem_req_o && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, {31'h0, bus.mem_req_o}, 32'h1);
    chk({tag, "_addr"}, {8'h0, bus.mem_A_o}, fa_q.size() > 0 ? {8'h0, fa_q.pop_front()} : 32'hDEAD);
  endtask
  task automatic ack(input int lat, input logic [7:0] d, input string tag);
    repeat (lat) @(negedge clk);
    chk({tag, "_held"}, {31'h0, bus.mem_req_o}, 32'h1);
    bus.mem_ack_i = 1'b1;
    bus.mem_D_i = d;
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.mem_D_i = 8'h00;
    chk({tag, "_drop"}, {31'h0, bus.mem_req_o}, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    bus.A_i = 4'h0;
    bus.D_i = 8'h00;
    bus.nWR_i = 1'b1;
    bus.nRD_i = 1'b1;
    bus.mem_ack_i = 1'b0;
    bus.mem_D_i = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_dout", {24'h0, bus.D_o}, 32'h0);
    chk("rst_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_maddr", {8'h0, bus.mem_A_o}, 32'h0);
    rst_n = 1'b1;
    rd(4'h3, 8'h00, "stat_rst");
    rd(4'h7, 8'hFF, "unmapped");
    wr(4'h0, 8'h12);
    wr(4'h1, 8'h34);
    wr(4'h2, 8'h56);
    rd(4'h0, 8'h12, "addr_lo");
    rd(4'h2, 8'h56, "addr_hi");
    fa_q.push_back(24'h563412);
    wr(4'h3, 8'h01);
    fetch("basic");
    rd(4'h3, 8'h02, "stat_busy");
    rd(4'hF, 8'hFF, "data_busy");
    ack(3, 8'hA5, "basic");
    rd(4'h3, 8'h01, "stat_valid");
    fa_q.push_back(24'h563413);
    rd(4'hF, 8'hA5, "data_basic");
    fetch("next");
    rd(4'h0, 8'h13, "addr_inc");
    ack(0, 8'h3C, "next");
    fa_q.push_back(24'h563414);
    rd(4'hF, 8'h3C, "data_hold", 10);
    fetch("hold");
    ack(1, 8'h77, "hold");
    repeat (3) @(negedge clk);
    chk("no_refetch", {31'h0, bus.mem_req_o}, 32'h0);
    rd(4'h0, 8'h14, "hold_addr");
    wr(4'h0, 8'hFF);
    wr(4'h1, 8'hFF);
    wr(4'h2, 8'hFF);
    rd(4'h3, 8'h00, "stat_addr_clr");
    fa_q.push_back(24'hFFFFFF);
    wr(4'h3, 8'h01);
    fetch("wrap0");
    ack(2, 8'hC3, "wrap0");
    fa_q.push_back(24'h000000);
    rd(4'hF, 8'hC3, "data_wrap");
    fetch("wrap1");
    ack(0, 8'h11, "wrap1");
    rd(4'h2, 8'h00, "addr_wrap_hi");
    fa_q.push_back(24'h000000);
    wr(4'h3, 8'h01);
    fetch("disc");
    wr(4'h0, 8'h40);
    ack(1, 8'h5A, "disc");
    rd(4'h3, 8'h00, "stat_discard");
    rd(4'hF, 8'hFF, "data_discard");
    rd(4'h0, 8'h40, "addr_discard");
    fa_q.push_back(24'h000040);
    wr(4'h3, 8'h01);
    fetch("tmo");
    c = 0;
    while (bus.mem_req_o && c < 300) begin
      c++;
      @(negedge clk);
    end
    chk("tmo_cycles", c, 255);
    rd(4'h3, 8'h04, "stat_timeout");
    rd(4'hF, 8'hFF, "data_timeout");
    fa_q.push_back(24'h000040);
    wr(4'h3, 8'h01);
    fetch("restart");
    ack(0, 8'h99, "restart");
    rd(4'h3, 8'h01, "stat_err_clr");
    fa_q.push_back(24'h000040);
    wr(4'h3, 8'h01);
    fetch("rst");
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("async_dout", {24'h0, bus.D_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'h3, 8'h00, "stat_rst2");
    rd(4'h0, 8'h00, "addr_rst2");
    chk("queues_empty", rd_q.size() + fa_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tfr_mem_rd.md
# tfr_mem_rd

Read-back transfer block: lets the support CPU fetch bytes from SDRAM through the same 16-register bus window used for memory writes. The CPU loads a 24-bit start address, triggers a fetch, then streams bytes out of a data register; each data read auto-increments the address and prefetches the next byte. The block is the initiator towards the SDRAM controller's byte-read port (req/ack handshake) and the responder on the support-CPU bus. Everything runs in the bus clock domain.

## Interface
- TIMEOUT, 255: max cycles mem_req_o may stay high without mem_ack_i before the fetch is abandoned (1..255).

- busclk_i  in  1  single clock; all logic on rising edge.
- nreset_i  in  1  asynchronous, active-low reset.
- A_i  in  4  register select.
- D_i  in  8  write data from support CPU.
- D_o  out  8  registered read data to support CPU.
- nWR_i  in  1  write strobe, active low.
- nRD_i  in  1  read strobe, active low.
- mem_A_o  out  24  SDRAM byte address for the current fetch.
- mem_req_o  out  1  fetch request, held until ack or timeout.
- mem_ack_i  in  1  SDRAM controller accept/data-valid, one cycle.
- mem_D_i  in  8  fetched byte, valid in the cycle mem_ack_i is high.

## Operation
- Register map: 0/1/2 = address [7:0]/[15:8]/[23:16] R/W; 3 = status R (bit0 VALID, bit1 BUSY, bit2 ERR, bits 7:3 = 0), W bit0=1 = START; F = data R only; all other reads return 8'hFF, other writes ignored.
- Strobes are edge-qualified: an access happens once, on the first cycle nRD_i/nWR_i is sampled low after being high (previous-value registers reset to 1). Holding a strobe low has no further effect.
- FSM states: IDLE, REQ.
- IDLE -> REQ on START write (clears VALID, ERR) or on valid data read (see below); loads mem_A_o from the address register, clears timeout counter, sets mem_req_o.
- REQ: mem_req_o and mem_A_o stable. On mem_ack_i=1: buffer <= mem_D_i, VALID <= 1 (unless DISCARD set), mem_req_o <= 0, -> IDLE. Else counter increments; when counter reaches TIMEOUT: mem_req_o <= 0, ERR <= 1, buffer <= 8'hFF, VALID stays 0, -> IDLE.
- Data read (F) with VALID=1: D_o <= buffer, VALID <= 0, address <= address+1 (24-bit, 0xFFFFFF wraps to 0x000000), next fetch starts at the incremented address in the same cycle.
- Data read with VALID=0 (fetching, idle or error): D_o <= 8'hFF, no side effects.
- Address write (0/1/2): always accepted; clears VALID. If in REQ, sets DISCARD: handshake completes normally (request never withdrawn) but byte is dropped. DISCARD clears on leaving REQ.
- START write while BUSY: ignored.
- Simultaneous read and write edges: both processed; read returns pre-write value.
- mem_ack_i while IDLE: ignored.
- BUSY = (state == REQ).

## Timing
- Reset (async, immediate): state IDLE, D_o=8'h00, mem_A_o=0, mem_req_o=0, address=0, buffer=8'hFF, VALID/ERR/DISCARD=0, counter=0.
- Strobe edge sampled at edge k -> D_o / register update visible after edge k (1-cycle read latency).
- START sampled at edge k -> mem_req_o=1 and mem_A_o valid after edge k; earliest ack sampled at edge k+1.
- Ack sampled at edge m -> mem_req_o=0, VALID=1 after edge m; status read at edge m+1 or later sees VALID.
- Timeout: req high exactly TIMEOUT cycles, then drops with ERR=1.
- Back-to-back stream: one byte per (2 + controller ack latency) cycles minimum.

## Test plan
- Reset: assert nreset_i mid-REQ -> mem_req_o drops without waiting for clock; D_o=00, status read = 8'h00.
- Basic: write 0x12,0x34,0x56 to regs 0,1,2, START; ack after 3 cycles with 0xA5 -> mem_A_o=0x563412, status=01, read F -> D_o=A5, next fetch at 0x563413.
- Wrap: address 0xFFFFFF, fetch, read F -> next mem_A_o=0x000000.
- Discard: START, write reg 0 during REQ, ack with 0x5A -> VALID=0, read F returns FF, address unchanged.
- Timeout: START, never ack -> mem_req_o high 255 cycles, then status=04, read F -> FF.
- Strobe hold: hold nRD_i low 10 cycles on F with VALID=1 -> exactly one increment and one fetch; read F while BUSY -> FF, no fetch.
